regfile_write_arbiter: RTL and testbench

Shares the single write port of the dual-read register file between three write sources: ALU writeback, RAM load and host/debug. It grants one requester per cycle by round-robin, with a host lock for exclusive bursts. It registers the winning write and drives the opcode, address, data and write enable the register file needs to commit it. It sits between the execute/memory stages and the register file write inputs.

---
 rtl/regfile_write_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port between the ALU
// writeback (0), RAM load (1) and host/debug (2) requesters. Round-robin
// grant with a host lock for exclusive bursts; the winning write is
// registered and presented to the register file for one cycle.
// Optional build macro ARB_STATS_EN adds saturating grant/stall counters.

`ifdef ARB_STATS_EN
// Saturating event counter, one instance per tracked event.
module arb_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  // Count up on inc and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule
`endif

module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            req_valid,
  output logic [2:0]            req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_2,
  input  logic [DATA_WIDTH-1:0] req_data_0,
  input  logic [DATA_WIDTH-1:0] req_data_1,
  input  logic [DATA_WIDTH-1:0] req_data_2,
  input  logic                  host_lock,
  output logic [15:0]           rf_opcode,
  output logic [ADDR_WIDTH-1:0] rf_addr_3,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  rf_write_enable,
  output logic [1:0]            grant_id,
  output logic                  locked
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]           grant_count_0,
  output logic [15:0]           grant_count_1,
  output logic [15:0]           grant_count_2,
  output logic [15:0]           stall_count
`endif
);
  localparam int          NUM_REQ = 3;
  localparam logic [15:0] OP_ALU  = 16'h1000;
  localparam logic [15:0] OP_LOAD = 16'h9200;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  typedef struct packed {
    logic                  we;
    logic [15:0]           op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_t;

  typedef enum logic [1:0] {
    S_ARB    = 2'b01,
    S_LOCKED = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] last_q, last_d;
  wr_t        wr_q, wr_d;

  req_t       req [NUM_REQ];
  logic [1:0] ord [NUM_REQ];
  logic [1:0] gnt_idx;
  logic       xfer;
  logic       found;

  // Gather per-requester payloads so the winner can be selected by index.
  always_comb begin
    req[0] = '{addr: req_addr_0, data: req_data_0};
    req[1] = '{addr: req_addr_1, data: req_data_1};
    req[2] = '{addr: req_addr_2, data: req_data_2};
  end

  // Search order: the requester after the last winner is tried first.
  always_comb begin
    case (last_q)
      2'd0:    ord = '{2'd1, 2'd2, 2'd0};
      2'd1:    ord = '{2'd2, 2'd0, 2'd1};
      default: ord = '{2'd0, 2'd1, 2'd2};
    endcase
  end

  // Grant: first valid requester in search order; only the host while locked.
  always_comb begin
    req_ready = '0;
    found     = 1'b0;
    if (state_q == S_LOCKED) begin
      req_ready[2] = req_valid[2];
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && req_valid[ord[k]]) begin
          req_ready[ord[k]] = 1'b1;
          found             = 1'b1;
        end
      end
    end
  end

  assign xfer    = |req_ready;
  assign gnt_idx = req_ready[1] ? 2'd1 : (req_ready[2] ? 2'd2 : 2'd0);

  // Lock FSM and last-winner tracking; stray encodings fall back to ARB.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      S_ARB:    if (req_ready[2] && host_lock) state_d = S_LOCKED;
      S_LOCKED: if (!host_lock)                state_d = S_ARB;
      default:                                 state_d = S_ARB;
    endcase
    if (xfer) last_d = gnt_idx;
  end

  // Registered write: strobe every cycle, payload only updates on a transfer.
  always_comb begin
    wr_d    = wr_q;
    wr_d.we = xfer;
    if (xfer) begin
      wr_d.op   = (gnt_idx == 2'd0) ? OP_ALU : OP_LOAD;
      wr_d.addr = req[gnt_idx].addr;
      wr_d.data = req[gnt_idx].data;
    end
  end

  // State registers; reset discards any write not yet committed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_ARB;
      last_q  <= 2'd2;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
    end
  end

  assign rf_write_enable = wr_q.we;
  assign rf_opcode       = wr_q.op;
  assign rf_addr_3       = wr_q.addr;
  assign rf_write_data   = wr_q.data;
  assign grant_id        = last_q;
  assign locked          = (state_q == S_LOCKED);

`ifdef ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] gcnt;
  logic                     stall;

  assign stall = |(req_valid & ~req_ready);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_gcnt
    arb_sat_cnt #(.W(16)) u_gcnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (req_ready[g]),
      .cnt     (gcnt[g])
    );
  end

  arb_sat_cnt #(.W(16)) u_stall (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stall),
    .cnt     (stall_count)
  );

  assign grant_count_0 = gcnt[0];
  assign grant_count_1 = gcnt[1];
  assign grant_count_2 = gcnt[2];
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: a reference round-robin/lock model predicts
// grants; accepted writes go to a queue and are checked when they reach the
// register file outputs one cycle later.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready;
  logic [3:0]  req_addr_0 = '0, req_addr_1 = '0, req_addr_2 = '0;
  logic [15:0] req_data_0 = '0, req_data_1 = '0, req_data_2 = '0;
  logic        host_lock = 1'b0;
  logic [15:0] rf_opcode;
  logic [3:0]  rf_addr_3;
  logic [15:0] rf_write_data;
  logic        rf_write_enable;
  logic [1:0]  grant_id;
  logic        locked;
`ifdef ARB_STATS_EN
  logic [15:0] grant_count_0, grant_count_1, grant_count_2, stall_count;
`endif

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr_0      (req_addr_0),
    .req_addr_1      (req_addr_1),
    .req_addr_2      (req_addr_2),
    .req_data_0      (req_data_0),
    .req_data_1      (req_data_1),
    .req_data_2      (req_data_2),
    .host_lock       (host_lock),
    .rf_opcode       (rf_opcode),
    .rf_addr_3       (rf_addr_3),
    .rf_write_data   (rf_write_data),
    .rf_write_enable (rf_write_enable),
    .grant_id        (grant_id),
    .locked          (locked)
`ifdef ARB_STATS_EN
    ,
    .grant_count_0   (grant_count_0),
    .grant_count_1   (grant_count_1),
    .grant_count_2   (grant_count_2),
    .stall_count     (stall_count)
`endif
  );

  typedef struct {
    logic [15:0] op;
    logic [3:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // reference model state
  logic [1:0] m_last;
  bit         m_lock;
  int         m_gc[3];
  int         m_stall;

  function automatic logic [2:0] model_ready(input logic [2:0] v, input logic [1:0] last,
                                             input bit lk);
    logic [2:0] r;
    int idx;
    r = '0;
    if (lk) begin
      r[2] = v[2];
      return r;
    end
    for (int k = 1; k <= 3; k++) begin
      idx = (int'(last) + k) % 3;
      if (v[idx]) begin
        r[idx] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic int sat_inc(input int x);
    return (x < 65535) ? x + 1 : 65535;
  endfunction

  task automatic model_reset();
    m_last  = 2'd2;
    m_lock  = 0;
    m_stall = 0;
    for (int i = 0; i < 3; i++) m_gc[i] = 0;
    sbq.delete();
  endtask

  // One clock: predict and check the grant, queue the accepted write, then
  // check the registered outputs against the queue.
  task automatic step();
    logic [2:0]  er;
    logic [3:0]  a[3];
    logic [15:0] d[3];
    int          g;
    bit          lk_nxt;
    exp_t        e;
    @(negedge clk);
    a[0] = req_addr_0; a[1] = req_addr_1; a[2] = req_addr_2;
    d[0] = req_data_0; d[1] = req_data_1; d[2] = req_data_2;
    er = model_ready(req_valid, m_last, m_lock);
    n_vec++;
    if (req_ready !== er) begin
      n_err++;
      $display("FAIL req_ready: got %b want %b (valid %b)", req_ready, er, req_valid);
    end
    if (|(req_valid & ~er)) m_stall = sat_inc(m_stall);
    lk_nxt = m_lock;
    if (m_lock && !host_lock) lk_nxt = 0;
    if (er != 3'b000) begin
      g = er[0] ? 0 : (er[1] ? 1 : 2);
      e.op   = (g == 0) ? 16'h1000 : 16'h9200;
      e.addr = a[g];
      e.data = d[g];
      sbq.push_back(e);
      m_gc[g] = sat_inc(m_gc[g]);
      m_last  = 2'(g);
      if (!m_lock && g == 2 && host_lock) lk_nxt = 1;
    end
    m_lock = lk_nxt;
    @(posedge clk);
    #1;
    n_vec++;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if ({rf_write_enable, rf_opcode, rf_addr_3, rf_write_data} !== {1'b1, e.op, e.addr, e.data}) begin
        n_err++;
        $display("FAIL rf_write: got we=%b op=%h a=%h d=%h want we=1 op=%h a=%h d=%h",
                 rf_write_enable, rf_opcode, rf_addr_3, rf_write_data, e.op, e.addr, e.data);
      end
    end else if (rf_write_enable !== 1'b0) begin
      n_err++;
      $display("FAIL rf_idle: got we=%b want 0", rf_write_enable);
    end
    n_vec++;
    if ({locked, grant_id} !== {m_lock, m_last}) begin
      n_err++;
      $display("FAIL state: got locked=%b grant_id=%0d want locked=%b grant_id=%0d",
               locked, grant_id, m_lock, m_last);
    end
`ifdef ARB_STATS_EN
    n_vec++;
    if ({grant_count_0, grant_count_1, grant_count_2, stall_count} !==
        {16'(m_gc[0]), 16'(m_gc[1]), 16'(m_gc[2]), 16'(m_stall)}) begin
      n_err++;
      $display("FAIL stats: got %0d %0d %0d stall %0d want %0d %0d %0d stall %0d",
               grant_count_0, grant_count_1, grant_count_2, stall_count,
               m_gc[0], m_gc[1], m_gc[2], m_stall);
    end
`endif
  endtask

  task automatic apply_reset();
    req_valid = '0;
    host_lock = 1'b0;
    reset_n   = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    req_valid = '0;
    host_lock = 1'b0;
    #2;
    reset_n = 1'b0;
    #2;
    n_vec++;
    if ({rf_write_enable, rf_opcode, rf_addr_3, rf_write_data, grant_id, locked, req_ready} !==
        {1'b0, 16'h0, 4'h0, 16'h0, 2'd2, 1'b0, 3'b000}) begin
      n_err++;
      $display("FAIL reset_vals: got we=%b op=%h a=%h d=%h gid=%0d lk=%b rdy=%b",
               rf_write_enable, rf_opcode, rf_addr_3, rf_write_data, grant_id, locked, req_ready);
    end
`ifdef ARB_STATS_EN
    n_vec++;
    if ({grant_count_0, grant_count_1, grant_count_2, stall_count} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_stats: got %h %h %h %h", grant_count_0, grant_count_1,
               grant_count_2, stall_count);
    end
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    apply_reset();
    req_addr_0 = 4'd3;
    req_data_0 = 16'hBEEF;
    req_valid  = 3'b001;
    step();
    n_vec++;
    if ({rf_write_enable, rf_opcode, rf_addr_3, rf_write_data} !== {1'b1, 16'h1000, 4'd3, 16'hBEEF}) begin
      n_err++;
      $display("FAIL single_write: got we=%b op=%h a=%h d=%h want 1 1000 3 beef",
               rf_write_enable, rf_opcode, rf_addr_3, rf_write_data);
    end
    req_valid = 3'b000;
    step();
    n_vec++;
    if ({rf_write_enable, rf_opcode, rf_addr_3, rf_write_data} !== {1'b0, 16'h1000, 4'd3, 16'hBEEF}) begin
      n_err++;
      $display("FAIL single_hold: got we=%b op=%h a=%h d=%h want 0 1000 3 beef",
               rf_write_enable, rf_opcode, rf_addr_3, rf_write_data);
    end
  endtask

  task automatic test_rotate();
    logic [1:0]  eg[6];
    logic [15:0] eo[6];
    eg = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    eo = '{16'h1000, 16'h9200, 16'h9200, 16'h1000, 16'h9200, 16'h9200};
    apply_reset();
    req_addr_0 = 4'd1; req_data_0 = 16'h0A0A;
    req_addr_1 = 4'd2; req_data_1 = 16'h0B0B;
    req_addr_2 = 4'd0; req_data_2 = 16'h0C0C;
    req_valid  = 3'b111;
    for (int i = 0; i < 6; i++) begin
      step();
      n_vec++;
      if ({rf_write_enable, grant_id, rf_opcode} !== {1'b1, eg[i], eo[i]}) begin
        n_err++;
        $display("FAIL rotate[%0d]: got we=%b gid=%0d op=%h want 1 %0d %h",
                 i, rf_write_enable, grant_id, rf_opcode, eg[i], eo[i]);
      end
    end
    req_valid = 3'b000;
    step();
  endtask

  task automatic test_host_lock();
    int s0;
    apply_reset();
    req_addr_0 = 4'd5; req_data_0 = 16'h1111;
    req_addr_1 = 4'd6; req_data_1 = 16'h2222;
    req_addr_2 = 4'd7; req_data_2 = 16'hA5A5;
    host_lock  = 1'b1;
    req_valid  = 3'b100;
    step();
    n_vec++;
    if (locked !== 1'b1) begin
      n_err++;
      $display("FAIL lock_enter: got locked=%b want 1", locked);
    end
    s0 = m_stall;
    req_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if ({rf_write_enable, grant_id, rf_addr_3} !== {1'b1, 2'd2, 4'd7}) begin
        n_err++;
        $display("FAIL lock_only_host[%0d]: got we=%b gid=%0d a=%h want 1 2 7",
                 i, rf_write_enable, grant_id, rf_addr_3);
      end
    end
`ifdef ARB_STATS_EN
    n_vec++;
    if (stall_count !== 16'(s0 + 4)) begin
      n_err++;
      $display("FAIL lock_stall: got %0d want %0d", stall_count, s0 + 4);
    end
`endif
    host_lock = 1'b0;
    step();
    step();
    n_vec++;
    if ({locked, grant_id, rf_opcode} !== {1'b0, 2'd0, 16'h1000}) begin
      n_err++;
      $display("FAIL lock_exit: got locked=%b gid=%0d op=%h want 0 0 1000",
               locked, grant_id, rf_opcode);
    end
    req_valid = 3'b000;
    step();
  endtask

  task automatic test_drop();
    bit seen9;
    seen9 = 0;
    apply_reset();
    req_addr_1 = 4'd5; req_data_1 = 16'h5555;
    req_valid  = 3'b010;
    step();
    req_addr_0 = 4'd2; req_data_0 = 16'h2020;
    req_addr_1 = 4'd9; req_data_1 = 16'h9999;
    req_addr_2 = 4'd4; req_data_2 = 16'h4040;
    req_valid  = 3'b111;
    for (int i = 0; i < 2; i++) begin
      step();
      if (rf_write_enable && rf_addr_3 == 4'd9) seen9 = 1;
    end
    req_valid = 3'b101;
    for (int i = 0; i < 3; i++) begin
      step();
      if (rf_write_enable && rf_addr_3 == 4'd9) seen9 = 1;
    end
    n_vec++;
    if (seen9 !== 1'b0) begin
      n_err++;
      $display("FAIL drop: dropped request reached rf (seen=%b want 0)", seen9);
    end
    req_valid = 3'b000;
    step();
  endtask

  task automatic test_reset_midop();
    apply_reset();
    req_addr_2 = 4'd6;
    req_data_2 = 16'h1234;
    req_valid  = 3'b100;
    step();
    req_valid = 3'b000;
    reset_n   = 1'b0;
    #1;
    n_vec++;
    if ({rf_write_enable, rf_opcode, rf_addr_3, rf_write_data, grant_id, locked} !==
        {1'b0, 16'h0, 4'h0, 16'h0, 2'd2, 1'b0}) begin
      n_err++;
      $display("FAIL reset_midop: got we=%b op=%h a=%h d=%h gid=%0d lk=%b want all reset",
               rf_write_enable, rf_opcode, rf_addr_3, rf_write_data, grant_id, locked);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      req_valid  = 3'($urandom_range(0, 7));
      host_lock  = ($urandom_range(0, 4) == 0);
      req_addr_0 = 4'($urandom); req_data_0 = 16'($urandom);
      req_addr_1 = 4'($urandom); req_data_1 = 16'($urandom);
      req_addr_2 = 4'($urandom); req_data_2 = 16'($urandom);
      step();
    end
    req_valid = 3'b000;
    host_lock = 1'b0;
    step();
    step();
  endtask

`ifdef ARB_STATS_EN
  task automatic test_saturate();
    apply_reset();
    req_addr_0 = 4'd0;
    req_data_0 = 16'h00FF;
    req_valid  = 3'b001;
    repeat (70000) step();
    n_vec++;
    if (grant_count_0 !== 16'hFFFF) begin
      n_err++;
      $display("FAIL saturate: got %h want ffff", grant_count_0);
    end
    req_valid = 3'b000;
    step();
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_rotate();
    test_host_lock();
    test_drop();
    test_reset_midop();
    test_random();
`ifdef ARB_STATS_EN
    test_saturate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
